// File: rtl/fat_dir_pkg.sv
// Shared FAT directory-entry layout used by the entry reader and writer.
// Field offsets, marker values, writer state encoding and the byte formatter.
package fat_dir_pkg;

    localparam int ENTRY_BYTES = 32;
    localparam int NAME_LEN    = 11;
    localparam int OFF_ATTR    = 11;
    localparam int OFF_CLUSTER = 26;
    localparam int OFF_SIZE    = 28;

    localparam logic [7:0] DELETED_MARK = 8'hE5;

    typedef enum logic [1:0] {
        ST_IDLE,
        ST_WRITE,
        ST_DONE
    } state_t;

    // Byte at entry offset idx for a normal (non-deleted) entry.
    function automatic logic [7:0] entry_byte(
        input logic [4:0]  idx,
        input logic [87:0] title,
        input logic [7:0]  attr,
        input logic [15:0] cluster,
        input logic [31:0] size
    );
        int          k;
        logic [87:0] t;
        logic [31:0] s;
        logic [7:0]  b;
        k = int'(idx);
        t = '0;
        s = '0;
        b = 8'h00;
        unique case (1'b1)
            (k < NAME_LEN): begin
                t = title >> (8 * (NAME_LEN - 1 - k));
                b = t[7:0];
            end
            (k == OFF_ATTR):        b = attr;
            (k == OFF_CLUSTER):     b = cluster[7:0];
            (k == OFF_CLUSTER + 1): b = cluster[15:8];
            (k >= OFF_SIZE): begin
                s = size >> (8 * (k - OFF_SIZE));
                b = s[7:0];
            end
            default:                b = 8'h00;
        endcase
        return b;
    endfunction

endpackage

// File: rtl/write_directory_entry.sv
// Formats one 32-byte FAT directory entry and streams it into the
// directory BRAM one byte per cycle, or stamps the deleted marker.
module write_directory_entry #(
    parameter int         ADDR_W    = 9,
    parameter logic [7:0] ATTR_BYTE = 8'h20
) (
    input  logic              clk,
    input  logic              rst,
    input  logic [ADDR_W-1:0] entry_start_addr,
    input  logic [87:0]       song_title,
    input  logic [15:0]       start_cluster,
    input  logic [31:0]       file_size,
    input  logic              delete_req,
    input  logic              in_valid,
    output logic              in_ready,
    output logic [ADDR_W-1:0] dir_bram_addr,
    output logic [7:0]        dir_bram_data,
    output logic              dir_bram_we,
    output logic              busy,
    output logic              out_valid
);

    import fat_dir_pkg::*;

    state_t            state;
    logic [4:0]        idx;
    logic [4:0]        nxt;
    logic [4:0]        last;
    logic              accept;
    logic [ADDR_W-1:0] lat_start;
    logic [87:0]       lat_title;
    logic [15:0]       lat_cluster;
    logic [31:0]       lat_size;
    logic              lat_del;

    assign accept = in_valid && in_ready;
    assign nxt    = idx + 5'd1;
    assign last   = lat_del ? 5'd0 : 5'(ENTRY_BYTES - 1);

    function automatic logic [7:0] fmt(
        input logic        del,
        input logic [4:0]  k,
        input logic [87:0] title,
        input logic [15:0] cluster,
        input logic [31:0] size
    );
        return del ? DELETED_MARK
                   : entry_byte(k, title, ATTR_BYTE, cluster, size);
    endfunction

    // Outputs are registered, so each write is formatted one edge early.
    always_ff @(posedge clk) begin
        if (rst) begin
            state         <= ST_IDLE;
            idx           <= 5'd0;
            in_ready      <= 1'b1;
            busy          <= 1'b0;
            out_valid     <= 1'b0;
            dir_bram_we   <= 1'b0;
            dir_bram_addr <= '0;
            dir_bram_data <= 8'h00;
            lat_start     <= '0;
            lat_title     <= '0;
            lat_cluster   <= '0;
            lat_size      <= '0;
            lat_del       <= 1'b0;
        end else begin
            unique case (state)
                ST_IDLE: begin
                    if (accept) begin
                        lat_start     <= entry_start_addr;
                        lat_title     <= song_title;
                        lat_cluster   <= start_cluster;
                        lat_size      <= file_size;
                        lat_del       <= delete_req;
                        state         <= ST_WRITE;
                        idx           <= 5'd0;
                        in_ready      <= 1'b0;
                        busy          <= 1'b1;
                        dir_bram_we   <= 1'b1;
                        dir_bram_addr <= entry_start_addr;
                        dir_bram_data <= fmt(delete_req, 5'd0, song_title,
                                             start_cluster, file_size);
                    end
                end
                ST_WRITE: begin
                    if (idx == last) begin
                        state       <= ST_DONE;
                        dir_bram_we <= 1'b0;
                        out_valid   <= 1'b1;
                    end else begin
                        idx           <= nxt;
                        dir_bram_addr <= lat_start + ADDR_W'(nxt);
                        dir_bram_data <= fmt(lat_del, nxt, lat_title,
                                             lat_cluster, lat_size);
                    end
                end
                ST_DONE: begin
                    state     <= ST_IDLE;
                    out_valid <= 1'b0;
                    busy      <= 1'b0;
                    in_ready  <= 1'b1;
                end
                default: state <= ST_IDLE;
            endcase
        end
    end

endmodule

// File: tb/tb_write_directory_entry.sv
// Directed bench for write_directory_entry with a BRAM model and
// per-write/per-done cycle logs for latency and count checks.
module tb_write_directory_entry;

    logic        clk = 1'b0;
    logic        rst;
    logic [8:0]  entry_start_addr;
    logic [87:0] song_title;
    logic [15:0] start_cluster;
    logic [31:0] file_size;
    logic        delete_req;
    logic        in_valid;
    logic        in_ready;
    logic [8:0]  dir_bram_addr;
    logic [7:0]  dir_bram_data;
    logic        dir_bram_we;
    logic        busy;
    logic        out_valid;

    write_directory_entry #(.ADDR_W(9), .ATTR_BYTE(8'h20)) dut (
        .clk(clk),
        .rst(rst),
        .entry_start_addr(entry_start_addr),
        .song_title(song_title),
        .start_cluster(start_cluster),
        .file_size(file_size),
        .delete_req(delete_req),
        .in_valid(in_valid),
        .in_ready(in_ready),
        .dir_bram_addr(dir_bram_addr),
        .dir_bram_data(dir_bram_data),
        .dir_bram_we(dir_bram_we),
        .busy(busy),
        .out_valid(out_valid)
    );

    always #5 clk = ~clk;

    logic [7:0] mem [512] = '{default: 8'hCC};
    int         cyc = 0;
    int         wr_cyc[$];
    int         ov_cyc[$];
    int         errors = 0;
    int         checks = 0;

    always @(posedge clk) begin
        cyc <= cyc + 1;
        if (dir_bram_we) begin
            mem[dir_bram_addr] <= dir_bram_data;
            wr_cyc.push_back(cyc);
        end
        if (out_valid) ov_cyc.push_back(cyc);
    end

    task automatic chk(input string tag, input logic [127:0] obs,
                       input logic [127:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s: observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    function automatic logic [127:0] rd_span(input logic [8:0] s,
                                             input int off, input int n);
        logic [127:0] r;
        r = '0;
        for (int k = 0; k < n; k++)
            r = {r[119:0], mem[s + 9'(off + k)]};
        return r;
    endfunction

    function automatic logic [31:0] rd_le32(input logic [8:0] s);
        return {mem[s + 9'd3], mem[s + 9'd2], mem[s + 9'd1], mem[s]};
    endfunction

    function automatic int wr_at(input int i);
        return (wr_cyc.size() > i) ? wr_cyc[i] : -1;
    endfunction

    function automatic int ov_at(input int i);
        return (ov_cyc.size() > i) ? ov_cyc[i] : -1;
    endfunction

    task automatic drive(input logic [8:0] s, input logic [87:0] t,
                         input logic [15:0] c, input logic [31:0] z,
                         input logic d);
        entry_start_addr = s;
        song_title       = t;
        start_cluster    = c;
        file_size        = z;
        delete_req       = d;
        in_valid         = 1'b1;
    endtask

    int c0;
    int wb;
    int ob;

    initial begin
        rst = 1'b1;
        in_valid = 1'b0;
        delete_req = 1'b0;
        entry_start_addr = '0;
        song_title = '0;
        start_cluster = '0;
        file_size = '0;
        repeat (3) @(negedge clk);
        rst = 1'b0;

        for (int n = 0; n < 10; n++) begin
            @(negedge clk);
            chk("reset_idle",
                {in_ready, dir_bram_we, busy, out_valid,
                 dir_bram_addr, dir_bram_data},
                {1'b1, 1'b0, 1'b0, 1'b0, 9'h000, 8'h00});
        end

        // Normal 32-byte write at 0x040
        wb = wr_cyc.size();
        ob = ov_cyc.size();
        drive(9'h040, "SONG1   MP3", 16'h1234, 32'h0001_E240, 1'b0);
        c0 = cyc;
        @(negedge clk);
        in_valid = 1'b0;
        chk("norm_c1", {busy, in_ready, dir_bram_we,
                        dir_bram_addr, dir_bram_data},
            {1'b1, 1'b0, 1'b1, 9'h040, 8'h53});
        repeat (31) @(negedge clk);
        chk("norm_c32", {dir_bram_we, dir_bram_addr, dir_bram_data},
            {1'b1, 9'h05F, 8'h00});
        @(negedge clk);
        chk("norm_c33", {out_valid, dir_bram_we, in_ready, busy},
            4'b1001);
        @(negedge clk);
        chk("norm_c34", {out_valid, in_ready, busy}, 3'b010);
        chk("norm_wr_cnt", wr_cyc.size() - wb, 32);
        chk("norm_first_wr", wr_at(wb), c0 + 1);
        chk("norm_last_wr", wr_at(wb + 31), c0 + 32);
        chk("norm_ov_cnt", ov_cyc.size() - ob, 1);
        chk("norm_ov_cyc", ov_at(ob), c0 + 33);
        chk("norm_title", rd_span(9'h040, 0, 11), 88'("SONG1   MP3"));
        chk("norm_attr", mem[9'h04B], 8'h20);
        chk("norm_zeros", rd_span(9'h040, 12, 14), 0);
        chk("norm_cluster", {mem[9'h05B], mem[9'h05A]}, 16'h1234);
        chk("norm_size", rd_span(9'h05C, 0, 4), 32'h40E2_0100);
        chk("norm_below", mem[9'h03F], 8'hCC);
        chk("norm_above", mem[9'h060], 8'hCC);

        // Delete at 0x080
        wb = wr_cyc.size();
        ob = ov_cyc.size();
        drive(9'h080, "DELETEMEMP3", 16'hFFFF, 32'hFFFF_FFFF, 1'b1);
        c0 = cyc;
        @(negedge clk);
        in_valid = 1'b0;
        delete_req = 1'b0;
        chk("del_c1", {dir_bram_we, dir_bram_addr, dir_bram_data},
            {1'b1, 9'h080, 8'hE5});
        @(negedge clk);
        chk("del_c2", {out_valid, dir_bram_we, in_ready}, 3'b100);
        @(negedge clk);
        chk("del_c3", {out_valid, in_ready, busy}, 3'b010);
        chk("del_wr_cnt", wr_cyc.size() - wb, 1);
        chk("del_ov_cyc", ov_at(ob), c0 + 2);
        chk("del_mark", mem[9'h080], 8'hE5);
        chk("del_next", mem[9'h081], 8'hCC);
        chk("del_tail", mem[9'h09F], 8'hCC);

        // Wrap at 0x1F0, second request held valid during busy
        wb = wr_cyc.size();
        ob = ov_cyc.size();
        drive(9'h1F0, "WRAPTESTMP3", 16'hBEEF, 32'h1122_3344, 1'b0);
        c0 = cyc;
        @(negedge clk);
        drive(9'h100, "SECOND  WAV", 16'h0102, 32'hA0B0_C0D0, 1'b0);
        repeat (32) @(negedge clk);
        chk("b2b_c33", {out_valid, in_ready}, 2'b10);
        @(negedge clk);
        chk("b2b_c34", {out_valid, in_ready}, 2'b01);
        @(negedge clk);
        in_valid = 1'b0;
        chk("b2b_c35", {dir_bram_we, dir_bram_addr, dir_bram_data},
            {1'b1, 9'h100, 8'h53});
        repeat (32) @(negedge clk);
        chk("b2b_c67", out_valid, 1'b1);
        @(negedge clk);
        chk("b2b_wr_cnt", wr_cyc.size() - wb, 64);
        chk("b2b_b_first_wr", wr_at(wb + 32), c0 + 35);
        chk("b2b_ov_a", ov_at(ob), c0 + 33);
        chk("b2b_ov_b", ov_at(ob + 1), c0 + 67);
        chk("b2b_ov_cnt", ov_cyc.size() - ob, 2);
        chk("wrap_title", rd_span(9'h1F0, 0, 11), 88'("WRAPTESTMP3"));
        chk("wrap_1ff", mem[9'h1FF], 8'h00);
        chk("wrap_cluster", {mem[9'h00B], mem[9'h00A]}, 16'hBEEF);
        chk("wrap_size", rd_le32(9'h00C), 32'h1122_3344);
        chk("wrap_below", mem[9'h1EF], 8'hCC);
        chk("wrap_above", mem[9'h010], 8'hCC);
        chk("b2b_b_title", rd_span(9'h100, 0, 11), 88'("SECOND  WAV"));
        chk("b2b_b_attr", mem[9'h10B], 8'h20);
        chk("b2b_b_cluster", {mem[9'h11B], mem[9'h11A]}, 16'h0102);
        chk("b2b_b_size", rd_le32(9'h11C), 32'hA0B0_C0D0);

        // Reset during the tenth write
        wb = wr_cyc.size();
        ob = ov_cyc.size();
        drive(9'h0C0, "RESETMIDMP3", 16'h5555, 32'h0000_0000, 1'b0);
        c0 = cyc;
        @(negedge clk);
        in_valid = 1'b0;
        repeat (9) @(negedge clk);
        chk("rst_c10", {dir_bram_we, dir_bram_addr}, {1'b1, 9'h0C9});
        rst = 1'b1;
        @(negedge clk);
        chk("rst_c11",
            {in_ready, dir_bram_we, busy, out_valid,
             dir_bram_addr, dir_bram_data},
            {1'b1, 1'b0, 1'b0, 1'b0, 9'h000, 8'h00});
        rst = 1'b0;
        repeat (40) @(negedge clk);
        chk("rst_wr_cnt", wr_cyc.size() - wb, 10);
        chk("rst_ov_cnt", ov_cyc.size() - ob, 0);
        chk("rst_last_byte", mem[9'h0C9], 8'h50);
        chk("rst_untouched", mem[9'h0CA], 8'hCC);

        wb = wr_cyc.size();
        ob = ov_cyc.size();
        drive(9'h0E0, "AFTERRSTMP3", 16'hA5A5, 32'h0000_0200, 1'b0);
        c0 = cyc;
        @(negedge clk);
        in_valid = 1'b0;
        repeat (33) @(negedge clk);
        chk("post_ready", in_ready, 1'b1);
        chk("post_wr_cnt", wr_cyc.size() - wb, 32);
        chk("post_ov_cyc", ov_at(ob), c0 + 33);
        chk("post_title", rd_span(9'h0E0, 0, 11), 88'("AFTERRSTMP3"));
        chk("post_cluster", {mem[9'h0FB], mem[9'h0FA]}, 16'hA5A5);
        chk("post_size", rd_le32(9'h0FC), 32'h0000_0200);

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule

// File: doc/write_directory_entry.md
# write_directory_entry

Writer counterpart to the directory-entry reader: formats one 32-byte FAT directory entry (11-byte song title, attribute, start cluster, file size) and writes it byte-by-byte into the directory BRAM. It sits between the song-catalog control logic and the directory BRAM write port, and it also supports marking an existing entry as deleted. One entry is written per accepted request, with a done pulse at the end.

## Interface
- ADDR_W, 9, directory BRAM byte-address width
- ATTR_BYTE, 8'h20, attribute byte written at entry offset 11 (archive)
- clk  input  1  system clock
- rst  input  1  synchronous, active-high reset
- entry_start_addr  input  ADDR_W  BRAM byte address of entry offset 0
- song_title  input  88  11-byte 8.3 name; bits [87:80] are offset 0, bits [7:0] are offset 10
- start_cluster  input  16  first cluster of the song
- file_size  input  32  song length in bytes
- delete_req  input  1  when high at accept, mark the entry deleted instead of writing it
- in_valid  input  1  request valid
- in_ready  output  1  high only in IDLE
- dir_bram_addr  output  ADDR_W  write address
- dir_bram_data  output  8  write data
- dir_bram_we  output  1  write enable
- busy  output  1  high in WRITE and DONE
- out_valid  output  1  one-cycle pulse when the entry is complete

## Operation
- Accept occurs on a cycle with in_valid && in_ready. At accept, latch all request inputs. in_valid while busy is ignored; nothing is queued.
- States:
  - IDLE: in_ready=1. On accept, go to WRITE with byte index i=0.
  - WRITE: drive we=1, addr=latched_start+i, data=byte(i). If i==last, go to DONE; otherwise increment i.
  - DONE: out_valid=1 for exactly one cycle, then return to IDLE.
- Normal-mode byte map (by offset):
  - 0–10: title bytes, MSB first.
  - 11: ATTR_BYTE.
  - 12–25: 8'h00.
  - 26: cluster[7:0].
  - 27: cluster[15:8].
  - 28–31: file_size, little-endian (28 is [7:0], 31 is [31:24]).
- In normal mode last=31, giving 32 writes.
- Delete mode: a single write of 8'hE5 at latched_start+0, so last=0. All other bytes are untouched.
- Address arithmetic is modulo 2^ADDR_W; an entry that crosses 511 wraps to 0.
- The byte index is 5 bits wide, so no overflow is possible.
- Title bytes are written exactly as given, with no space padding or case conversion. A title byte 0 equal to 8'hE5 is written unchanged (the caller's responsibility).

## Timing
- Reset values:
  - in_ready=1
  - dir_bram_we=0
  - dir_bram_addr=0
  - dir_bram_data=0
  - busy=0
  - out_valid=0
  - state=IDLE
  - i=0
  - latches=0
- All outputs are registered.
- Normal write (accept on cycle 0):
  - writes on cycles 1–32;
  - out_valid on cycle 33;
  - in_ready high again on cycle 34, where back-to-back accept is allowed.
- Delete (accept on cycle 0): write on cycle 1, out_valid on cycle 2, in_ready on cycle 3.
- dir_bram_we is 0 in every cycle outside WRITE. Addr and data hold their last values when we=0.
- Reset mid-operation:
  - the next cycle shows all reset values;
  - no further writes occur;
  - no out_valid is emitted;
  - the partially written entry stays as is.
- Reset has priority over accept in the same cycle.

## Structure
- Shared package fat_dir_pkg holds:
  - ENTRY_BYTES=32
  - NAME_LEN=11
  - OFF_ATTR=11
  - OFF_CLUSTER=26
  - OFF_SIZE=28
  - DELETED_MARK=8'hE5
  - the state enum
- The reader block imports the same offsets from this package.
- No sub-module. The byte map is a combinational function of i and the latched fields, placed in the package or the module.

## Test plan
- Reset then idle: all outputs hold their reset values and in_ready=1 for 10 cycles with in_valid=0.
- Normal write:
  - stimulus: start=9'h040, title="SONG1   MP3", cluster=16'h1234, size=32'h0001_E240;
  - required: exactly 32 writes to 0x040–0x05F; offset 0='S', offset 11=8'h20, 0x05A=8'h34, 0x05B=8'h12, 0x05C..0x05F=40,E2,01,00; out_valid on cycle 33.
- Delete: start=9'h080, delete_req=1 -> a single write of E5 at 0x080; out_valid 2 cycles after accept; no other BRAM bytes change.
- Wrap and back-to-back:
  - start=9'h1F0 -> writes to 0x1F0–0x1FF, then 0x000–0x00F;
  - a second request held valid during busy is accepted only when in_ready returns, using its own latched values.
- Reset mid-write: assert rst at write #10 -> no writes after it, no out_valid; the next request then completes normally.
